fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
Instruction fetch buffer that sits directly downstream of the PC register and feeds decode. It issues instruction-memory reads at pcF and tracks the single in-flight read. Returned instructions are queued with their PC and PC+4, and presented to decode on a valid/ready handshake. It drives the PC register's enable (back-pressure) and discards wrong-path work on an execute-stage redirect.

Parameters:
DATA_WIDTH, 32, width of PC, PC+4 and instruction words.
DEPTH, 4, queue entries; power of two, >= 2; >= 3 required for one instruction per cycle.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
pcF  in  DATA_WIDTH  current fetch PC from the PC register.
pc_plus4F  in  DATA_WIDTH  pcF + 4 from the PC register.
flush  in  1  execute-stage redirect taken (branch/jalr); wrong-path kill.
fetch_en  out  1  enable for the PC register.
imem_req  out  1  read request to instruction memory this cycle.
imem_addr  out  DATA_WIDTH  read address; equals pcF.
imem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after imem_req.
valid_d  out  1  head entry valid for decode.
ready_d  in  1  decode accepts head this cycle.
instr_d  out  DATA_WIDTH  head instruction.
pc_d  out  DATA_WIDTH  head PC.
pc_plus4_d  out  DATA_WIDTH  head PC+4.

Behaviour:
- Reset (async, rst=1): count=0, rd_ptr=wr_ptr=0, inflight_valid=0, inflight_pc/inflight_pc4=0, all storage 0. Outputs: valid_d=0, instr_d/pc_d/pc_plus4_d=0, imem_req=0. fetch_en=1 once occupancy=0 (combinational). First request is issued in the first cycle after rst deasserts.
- Occupancy is count + inflight_valid, ranging 0..DEPTH.
- space = (occupancy < DEPTH); there is no combinational dependence on ready_d.
- imem_req = space & ~flush. imem_addr = pcF at all times.
- fetch_en = space | flush. On a redirect the PC register must load the target; the request at the wrong-path pcF is suppressed.
- On imem_req, latch inflight_pc<=pcF and inflight_pc4<=pc_plus4F. inflight_valid <= imem_req. Any cycle without a request clears inflight_valid.
- Push: inflight_valid & ~flush writes {imem_rdata, inflight_pc, inflight_pc4} at wr_ptr, then wr_ptr++ mod DEPTH.
- Pop: valid_d & ready_d & ~flush advances rd_ptr++ mod DEPTH.
- Push and pop in the same cycle leave count unchanged. Pointers wrap naturally at DEPTH.
- valid_d = (count != 0). instr_d/pc_d/pc_plus4_d read storage[rd_ptr] combinationally; they are don't-care when valid_d=0 but must not be X after reset.
- Flush takes priority over push, pop and ready_d. Next cycle: count=0, rd_ptr=wr_ptr=0, inflight_valid=0, valid_d=0. The response returning during the flush cycle is dropped.
- Flush in consecutive cycles: each flush cycle behaves identically, with no requests issued.
- Back-pressure: with ready_d=0, at most DEPTH instructions are buffered/in flight. fetch_en drops when occupancy=DEPTH, and pcF holds.
- Push while count=DEPTH is unreachable. The bench asserts count<=DEPTH and no push when full.
- Latency: pcF presented at cycle t with request appears on valid_d at t+2. Steady-state throughput is 1 per cycle with ready_d=1 and DEPTH>=3.
- Reset mid-operation: all state clears immediately. No partial entry survives.

Test Plan:
- Reset release, ready_d=1, PC starting 0xBFC0000, imem word = address: valid_d rises 2 cycles after first request. pc_d sequence 0xBFC0000, 0xBFC0004, 0xBFC0008… at 1 per cycle; instr_d==pc_d; pc_plus4_d==pc_d+4.
- ready_d=0 from reset: exactly 4 requests issued (0xBFC0000..0xBFC000C), then fetch_en=0 and pcF holds at 0xBFC0010. Raising ready_d drains in order and fetch resumes with no lost or duplicated PC.
- Flush with 3 buffered + 1 in flight, target 0x100: the next cycle valid_d=0 and count=0. The first new request has imem_addr=0x100, and the next valid pc_d=0x100 appears 2 cycles later. No wrong-path PC ever reaches decode.
- Flush while ready_d=1 and valid_d=1: no pop counted, the head is discarded, and the following pc_d is the redirect target.
- Toggling ready_d (1,0,1,0…) for 40 cycles: the decode-accepted PC stream is strictly +4 sequential. count never exceeds 4, and pointer wrap is exercised at least twice.
- Async rst pulsed mid-stream with count=2, between clock edges: outputs go to 0 immediately without a clock edge. After release, fetch restarts at 0xBFC0000.

Source files
------------

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Instruction fetch buffer between the PC register and decode.
//            Issues instruction-memory reads at pcF and tracks the single
//            read in flight. Returned words are queued with their PC and
//            PC+4, then handed to decode on a valid/ready handshake.
//            Back-pressures the PC register through fetch_en and discards
//            all wrong-path work on an execute-stage redirect (flush).
// Ports    : clk, rst          - clock (rising edge), async active-high reset
//            pcF, pc_plus4F    - current fetch PC and PC+4 from PC register
//            flush             - execute-stage redirect, kills wrong path
//            fetch_en          - enable for the PC register
//            imem_req/addr     - instruction memory read request / address
//            imem_rdata        - read data, valid one cycle after imem_req
//            valid_d/ready_d   - decode handshake
//            instr_d, pc_d,
//            pc_plus4_d        - head entry presented to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pcF,
    input  logic [DATA_WIDTH-1:0] pc_plus4F,
    input  logic                  flush,
    output logic                  fetch_en,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  valid_d,
    input  logic                  ready_d,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    // Queue storage
    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0] pc4_q   [DEPTH];

    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic                  inflight_valid_q;
    logic [DATA_WIDTH-1:0] inflight_pc_q;
    logic [DATA_WIDTH-1:0] inflight_pc4_q;

    logic [CNT_W-1:0]      occupancy_w;
    logic                  space_w;
    logic                  push_w;
    logic                  pop_w;

    // The in-flight read already owns a slot, so it counts toward occupancy;
    // this is what guarantees a returning word always finds room.
    assign occupancy_w = count_q + {{(CNT_W-1){1'b0}}, inflight_valid_q};
    assign space_w     = (occupancy_w < C_DEPTH);

    // No request while reset is held: the first read goes out in the first
    // cycle after release. A flush suppresses the wrong-path request but
    // still enables the PC register so it can load the redirect target.
    assign imem_req  = space_w & ~flush & ~rst;
    assign imem_addr = pcF;
    assign fetch_en  = space_w | flush;

    assign valid_d    = (count_q != '0);
    assign instr_d    = instr_q[rd_ptr_q];
    assign pc_d       = pc_q[rd_ptr_q];
    assign pc_plus4_d = pc4_q[rd_ptr_q];

    assign push_w = inflight_valid_q & ~flush;
    assign pop_w  = valid_d & ready_d & ~flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q          <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_pc4_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
            end
        end else begin
            count_q          <= count_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            inflight_valid_q <= imem_req;
            if (imem_req) begin
                inflight_pc_q  <= pcF;
                inflight_pc4_q <= pc_plus4F;
            end
            if (push_w) begin
                instr_q[wr_ptr_q] <= imem_rdata;
                pc_q[wr_ptr_q]    <= inflight_pc_q;
                pc4_q[wr_ptr_q]   <= inflight_pc4_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Self-checking bench for fetch_buffer. Models the PC register
//            and an instruction memory whose word equals its address, and
//            keeps a queue-level reference of the buffer contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] C_RESET_PC = 32'h0BFC_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pcF = '0;
    logic [DW-1:0] pc_plus4F = '0;
    logic          flush = 1'b0;
    logic          fetch_en;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic          valid_d;
    logic          ready_d = 1'b0;
    logic [DW-1:0] instr_d;
    logic [DW-1:0] pc_d;
    logic [DW-1:0] pc_plus4_d;

    fetch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcF        (pcF),
        .pc_plus4F  (pc_plus4F),
        .flush      (flush),
        .fetch_en   (fetch_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .valid_d    (valid_d),
        .ready_d    (ready_d),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    logic        m_inf;
    logic [31:0] m_ipc;
    logic [31:0] m_pc;
    logic [31:0] m_rdata;
    logic [31:0] exp_next;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_push = 0;
    int n_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_inf    = 1'b0;
        m_ipc    = '0;
        m_pc     = C_RESET_PC;
        m_rdata  = '0;
        exp_next = C_RESET_PC;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        flush   = 1'b0;
        ready_d = 1'b0;
        pcF       = m_pc;
        pc_plus4F = m_pc + 32'd4;
        repeat (2) @(posedge clk);
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs,
    // then advance the model and the PC register / memory environment.
    task automatic cycle(input logic fl, input logic rdy, input logic [31:0] tgt);
        int  occ;
        logic e_req, e_fen, e_val;
        @(negedge clk);
        rst        = 1'b0;
        flush      = fl;
        ready_d    = rdy;
        pcF        = m_pc;
        pc_plus4F  = m_pc + 32'd4;
        imem_rdata = m_rdata;
        #1;
        occ   = mq.size() + (m_inf ? 1 : 0);
        e_req = (occ < DEPTH) && !fl;
        e_fen = (occ < DEPTH) || fl;
        e_val = (mq.size() != 0);

        chk("valid_d", {31'd0, valid_d}, {31'd0, e_val});
        chk("fetch_en", {31'd0, fetch_en}, {31'd0, e_fen});
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("count_bound", {31'd0, (dut.count_q <= DEPTH)}, 32'd1);
        chk("no_push_full", {31'd0, (dut.inflight_valid_q && dut.count_q == DEPTH)}, 32'd0);
        if (e_val) begin
            chk("instr_d", instr_d, mq[0].instr);
            chk("pc_d", pc_d, mq[0].pc);
            chk("pc_plus4_d", pc_plus4_d, mq[0].pc4);
        end
        // Decode-accepted stream must be gap-free and duplicate-free.
        if (valid_d && rdy && !fl) begin
            chk("accept_seq", pc_d, exp_next);
            exp_next = exp_next + 32'd4;
            n_acc++;
        end
        if (imem_req) n_req++;

        if (fl) begin
            mq.delete();
            m_inf    = 1'b0;
            exp_next = tgt;
        end else begin
            if (e_val && rdy) void'(mq.pop_front());
            if (m_inf) begin
                mq.push_back('{instr: m_rdata, pc: m_ipc, pc4: m_ipc + 32'd4});
                n_push++;
            end
            m_inf = e_req;
            m_ipc = m_pc;
        end
        m_rdata = m_pc;
        if (fl)         m_pc = tgt;
        else if (e_fen) m_pc = m_pc + 32'd4;
    endtask

    int acc0, push0;

    initial begin
        model_reset();
        do_reset();
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fetch_en", {31'd0, fetch_en}, 32'd1);
        chk("rst_pc_d", pc_d, 32'd0);

        // Streaming with ready_d=1: two-cycle latency, one per cycle
        cycle(1'b0, 1'b1, '0);
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0BFC_0000);
        cycle(1'b0, 1'b1, '0);
        chk("t1_valid_early", {31'd0, valid_d}, 32'd0);
        cycle(1'b0, 1'b1, '0);
        chk("t1_valid", {31'd0, valid_d}, 32'd1);
        chk("t1_pc0", pc_d, 32'h0BFC_0000);
        chk("t1_instr0", instr_d, 32'h0BFC_0000);
        chk("t1_pc4_0", pc_plus4_d, 32'h0BFC_0004);
        cycle(1'b0, 1'b1, '0);
        chk("t1_pc1", pc_d, 32'h0BFC_0004);
        cycle(1'b0, 1'b1, '0);
        chk("t1_pc2", pc_d, 32'h0BFC_0008);
        repeat (10) cycle(1'b0, 1'b1, '0);

        // Back-pressure from reset
        do_reset();
        n_req = 0;
        repeat (6) cycle(1'b0, 1'b0, '0);
        chk("t2_nreq", n_req, 32'd4);
        chk("t2_fetch_en", {31'd0, fetch_en}, 32'd0);
        chk("t2_pc_hold", pcF, 32'h0BFC_0010);
        cycle(1'b0, 1'b1, '0);
        chk("t2_drain0", pc_d, 32'h0BFC_0000);
        acc0 = n_acc;
        repeat (12) cycle(1'b0, 1'b1, '0);
        chk("t2_drained", n_acc - acc0, 32'd12);

        // Flush with 3 buffered + 1 in flight
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 32'h100);
        chk("t3_fl_req", {31'd0, imem_req}, 32'd0);
        chk("t3_fl_fen", {31'd0, fetch_en}, 32'd1);
        cycle(1'b0, 1'b0, '0);
        chk("t3_valid0", {31'd0, valid_d}, 32'd0);
        chk("t3_count0", {29'd0, dut.count_q}, 32'd0);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        chk("t3_pc", pc_d, 32'h100);
        repeat (5) cycle(1'b0, 1'b1, '0);

        // Flush while decode is accepting
        acc0 = n_acc;
        cycle(1'b1, 1'b1, 32'h200);
        chk("t4_valid_at_fl", {31'd0, valid_d}, 32'd1);
        chk("t4_no_pop", n_acc - acc0, 32'd0);
        cycle(1'b0, 1'b1, '0);
        chk("t4_valid0", {31'd0, valid_d}, 32'd0);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        chk("t4_pc", pc_d, 32'h200);

        // Toggling ready_d
        acc0  = n_acc;
        push0 = n_push;
        for (int i = 0; i < 40; i++) cycle(1'b0, (i % 2) == 0, '0);
        chk("t5_accepts", {31'd0, (n_acc - acc0) >= 16}, 32'd1);
        chk("t5_wraps", {31'd0, (n_push - push0) >= 2 * DEPTH}, 32'd1);

        // Asynchronous reset between clock edges with two entries buffered
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, '0);
        chk("t6_pre_valid", {31'd0, valid_d}, 32'd1);
        chk("t6_pre_count", {29'd0, dut.count_q}, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_valid", {31'd0, valid_d}, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd0);
        chk("t6_instr", instr_d, 32'd0);
        chk("t6_pc", pc_d, 32'd0);
        chk("t6_pc4", pc_plus4_d, 32'd0);
        model_reset();
        @(posedge clk);
        cycle(1'b0, 1'b1, '0);
        chk("t6_restart", imem_addr, 32'h0BFC_0000);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        chk("t6_pc0", pc_d, 32'h0BFC_0000);
        repeat (6) cycle(1'b0, 1'b1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
